// File: rtl/apb3_master_bridge.sv
// Command/response to APB3 initiator bridge: one outstanding transfer at a time,
// with an optional ACCESS-phase wait timeout that reports as a slave error.
module apb3_master_bridge #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERROR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [15:0]           wait_q, wait_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wait_d   = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          wait_d   = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A slave completion in the final timeout cycle takes priority over the abort.
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERROR;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 16'd1;
          if (TO_EN && (wait_q == WAIT_LAST)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      wait_q   <= wait_d;
    end
  end

  // Handshake and APB strobes are pure state decodes, so reset drops them at once.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign rsp_valid   = (state_q == ST_RESP);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench: directed scenarios plus randomized transfers against a
// transaction-level model of wait states, timeout and response back-pressure.
module tb_apb3_master_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_timeout;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERROR;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  apb3_master_bridge #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERROR(PSLVERROR)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: the slave raises PREADY on ACCESS cycle index 'waits'; if that index is
  // beyond the timeout window the bridge aborts after TO ACCESS cycles.
  task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rd, input bit serr, input int hold);
    bit          exp_tmo;
    int          exp_acc;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          acc;
    int          psel_n;
    exp_tmo = (waits >= TO);
    exp_acc = exp_tmo ? TO : waits + 1;
    exp_rd  = (exp_tmo || wr) ? 32'h0 : rd;
    exp_err = exp_tmo || serr;

    @(negedge clk);
    chk_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 12'($urandom); cmd_wdata = $urandom; cmd_write = ~wr;
    chk_eq("setup_strobes", 64'({PSEL, PENABLE}), 64'b10);
    chk_eq("setup_paddr", 64'(PADDR), 64'(addr));
    chk_eq("setup_pwrite", 64'(PWRITE), 64'(wr));
    chk_eq("setup_pwdata", 64'(PWDATA), 64'(wd));
    chk_eq("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    psel_n = 1;
    acc    = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && PSEL; i++) begin
      chk_eq("access_penable", 64'(PENABLE), 64'd1);
      chk_eq("access_paddr", 64'(PADDR), 64'(addr));
      chk_eq("access_pwdata", 64'(PWDATA), 64'(wd));
      PREADY    = (acc == waits);
      PRDATA    = (acc == waits) ? rd : $urandom;
      PSLVERROR = (acc == waits) ? serr : 1'($urandom);
      acc++;
      psel_n++;
      @(negedge clk);
    end
    PREADY = 1'b0; PSLVERROR = 1'b0; PRDATA = $urandom;
    chk_eq("access_cycles", 64'(acc), 64'(exp_acc));
    chk_eq("psel_cycles", 64'(psel_n), 64'(exp_acc + 1));
    for (int i = 0; i <= hold; i++) begin
      chk_eq("rsp_valid", 64'(rsp_valid), 64'd1);
      chk_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
      chk_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp_tmo));
      chk_eq("resp_strobes", 64'({PSEL, PENABLE, cmd_ready}), 64'b000);
      chk_eq("resp_paddr_hold", 64'(PADDR), 64'(addr));
      if (i == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk_eq("rsp_done", 64'(rsp_valid), 64'd0);
    chk_eq("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    $display("txn wr=%0d addr=0x%03h waits=%0d serr=%0d hold=%0d -> acc=%0d rdata=0x%08h err=%0d tmo=%0d",
             wr, addr, waits, serr, hold, acc, rsp_rdata, rsp_error, rsp_timeout);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERROR = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_strobes", 64'({PSEL, PENABLE, rsp_valid}), 64'b000);
    chk_eq("rst_paddr", 64'(PADDR), 64'd0);
    chk_eq("rst_pwdata", 64'(PWDATA), 64'd0);
    chk_eq("rst_rsp", 64'({rsp_rdata, rsp_error, rsp_timeout, PWRITE}), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    run_txn(1'b1, 12'h004, 32'h1, 0, 32'hDEADBEEF, 1'b0, 0);
    run_txn(1'b0, 12'h040, 32'h0, 2, 32'hABCD5678, 1'b0, 0);
    run_txn(1'b0, 12'h100, 32'h0, 10, 32'h12345678, 1'b0, 0);
    run_txn(1'b1, 12'h0FC, 32'hCAFE, 0, 32'h0, 1'b1, 5);
    run_txn(1'b0, 12'h080, 32'h0, TO - 1, 32'h55, 1'b0, 0);

    // Reset pulse in the middle of ACCESS.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h3A0; cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_eq("pre_rst_access", 64'({PSEL, PENABLE}), 64'b11);
    #2 resetn = 1'b0;
    #1;
    chk_eq("async_rst_strobes", 64'({PSEL, PENABLE, rsp_valid}), 64'b000);
    chk_eq("async_rst_paddr", 64'(PADDR), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq("no_rsp_after_rst", 64'({rsp_valid, cmd_ready}), 64'b01);
    end
    $display("txn reset mid-ACCESS addr=0x3a0 -> dropped");
    run_txn(1'b1, 12'h3A4, 32'h5A5A5A5A, 1, 32'h0, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 6)),
              $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
